// File: rtl/janken_hand_buffer.sv
// Janken hand buffer: synchronises and debounces the capture/clear/reveal
// inputs, stores one hand per player and sequences the reveal of a round.
module janken_hand_buffer #(
   parameter int PLAYERS  = 3,
   parameter int HAND_W   = 2,
   parameter int DEBOUNCE = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pon,
   input  logic                          gtp_,
   input  logic                          clr_,
   input  logic [HAND_W-1:0]             selecter_in,
   output logic [PLAYERS*HAND_W-1:0]     g_data_out,
   output logic [$clog2(PLAYERS+1)-1:0]  count,
   output logic                          full,
   output logic                          reveal_valid,
   output logic                          reject
);

   localparam int BW  = PLAYERS * HAND_W;
   localparam int CW  = $clog2(PLAYERS + 1);
   localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   // Released levels of the conditioned inputs, packed as {pon, clr_, gtp_}.
   localparam logic [2:0] REL = 3'b011;

   typedef enum logic [1:0] {COLLECT, FULL, REVEAL} state_e;

   logic [2:0]     raw, sync1, sync2, filt, filt_prev;
   logic [DCW-1:0] db_cnt [3];

   assign raw = {pon, clr_, gtp_};

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchroniser chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= REL;
         sync2     <= REL;
         filt      <= REL;
         filt_prev <= REL;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1     <= raw;
         sync2     <= sync1;
         filt_prev <= filt;
         for (int i = 0; i < 3; i++) begin
            // Count consecutive disagreeing cycles; any agreeing cycle restarts.
            if (sync2[i] != filt[i]) begin
               if (db_cnt[i] == DCW'(DEBOUNCE - 1)) begin
                  filt[i]   <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DCW'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   logic press, clear, pon_rise, pon_fall;
   assign press    =  filt_prev[0] & ~filt[0];
   assign clear    =  filt_prev[1] & ~filt[1];
   assign pon_rise = ~filt_prev[2] &  filt[2];
   assign pon_fall =  filt_prev[2] & ~filt[2];

   state_e         state, state_d;
   logic [BW-1:0]  hand_buf, hand_buf_d, snap, snap_d;
   logic [CW-1:0]  count_d;
   logic           reveal_d, reject_d;

   // NOTE: every output of this block gets a default first so no path leaves
   // a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state;
      hand_buf_d = hand_buf;
      snap_d     = snap;
      count_d    = count;
      reveal_d   = 1'b0;
      reject_d   = 1'b0;
      if (clear) begin
         state_d    = COLLECT;
         hand_buf_d = '0;
         snap_d     = '0;
         count_d    = '0;
      end else if (pon_rise || pon_fall) begin
         unique case (state)
            COLLECT: reject_d = pon_rise;
            FULL: if (pon_rise) begin
               snap_d   = hand_buf;
               reveal_d = 1'b1;
               state_d  = REVEAL;
            end
            REVEAL: if (pon_fall) begin
               hand_buf_d = '0;
               count_d    = '0;
               state_d    = COLLECT;
            end
            default: state_d = COLLECT;
         endcase
      end else if (press) begin
         if (state == COLLECT && selecter_in != '0) begin
            hand_buf_d = {hand_buf[BW-HAND_W-1:0], selecter_in};
            count_d    = count + CW'(1);
            if (count_d == CW'(PLAYERS)) state_d = FULL;
         end else begin
            reject_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= COLLECT;
         hand_buf     <= '0;
         snap         <= '0;
         count        <= '0;
         full         <= 1'b0;
         reveal_valid <= 1'b0;
         reject       <= 1'b0;
         g_data_out   <= '0;
      end else begin
         state        <= state_d;
         hand_buf     <= hand_buf_d;
         snap         <= snap_d;
         count        <= count_d;
         full         <= (count_d == CW'(PLAYERS));
         reveal_valid <= reveal_d;
         reject       <= reject_d;
         // Display follows the current state, so it lags a state change by one cycle.
         g_data_out   <= (state == REVEAL) ? snap : BW'(selecter_in);
      end
   end

endmodule
